// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared definitions for the bit-serial adder family.
//   state_t      2-bit FSM state encoding (IDLE, RUN, DONE)
//   MAX_WIDTH    largest supported operand width
package serial_adder_pkg;

    localparam int MAX_WIDTH = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle for serial_adder.
//   start, sub, a, b       request side (driven by the operand capture logic)
//   busy, done, sum, cout, ovf  result side (driven by the adder)
// master = requester, slave = adder.
interface serial_adder_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (output start, sub, a, b, input  busy, done, sum, cout, ovf);
    modport slave  (input  start, sub, a, b, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/full_adder_bit.sv
// full_adder_bit: combinational 1-bit full adder.
//   a, b, cin  addend bits and carry in
//   s          sum bit
//   cout       carry out (majority of the three inputs)
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder/subtractor, one bit per clock.
//   CLK   system clock, rising edge
//   RST   asynchronous active-high reset
//   bus   serial_adder_if slave: start/sub/a/b in, busy/done/sum/cout/ovf out
// An operation started at edge k finishes at edge k+WIDTH; done is high for
// the following cycle, during which a new start is accepted.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           CLK,
    input  logic           RST,
    serial_adder_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             c_msb_q, c_msb_d;   // carry into the MSB stage
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_s, fa_c;

    full_adder_bit u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (c_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        c_msb_d = c_msb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.start) begin
                    // Subtraction is a + ~b + 1: the +1 enters as initial carry.
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.sub ? ~bus.b : bus.b;
                    c_d     = bus.sub;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d  = {fa_s, res_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                c_d    = fa_c;
                cnt_d  = CW'(cnt_q + 1'b1);
                if (cnt_q == CNT_PRE)
                    c_msb_d = fa_c;
                if (cnt_q == CNT_LAST) begin
                    sum_d   = res_d;
                    cout_d  = fa_c;
                    ovf_d   = c_msb_q ^ fa_c;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            c_msb_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            c_msb_q <= c_msb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic CLK, RST;
    int   n_cmp = 0;
    int   n_mis = 0;

    serial_adder_if #(.WIDTH(8)) i8 ();
    serial_adder_if #(.WIDTH(2)) i2 ();

    serial_adder #(.WIDTH(8)) u_d8 (.CLK(CLK), .RST(RST), .bus(i8.slave));
    serial_adder #(.WIDTH(2)) u_d2 (.CLK(CLK), .RST(RST), .bus(i2.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Start one WIDTH=8 op; returns edges from start to done and busy cycles seen.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output int lat, output int bcnt);
        i8.start = 1'b1; i8.a = a; i8.b = b; i8.sub = s;
        step();
        i8.start = 1'b0;
        lat = 0; bcnt = 0;
        while (!i8.done && lat < 40) begin
            if (i8.busy) bcnt++;
            step();
            lat++;
        end
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic s,
                       output int lat);
        i2.start = 1'b1; i2.a = a; i2.b = b; i2.sub = s;
        step();
        i2.start = 1'b0;
        lat = 0;
        while (!i2.done && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic res8(input string tag, input logic [7:0] s, input logic c, input logic o);
        chk(tag, 64'({i8.sum, i8.cout, i8.ovf}), 64'({s, c, o}));
    endtask

    initial begin
        int lat, bcnt, ndone;
        RST = 1'b1;
        i8.start = 1'b0; i8.sub = 1'b0; i8.a = '0; i8.b = '0;
        i2.start = 1'b0; i2.sub = 1'b0; i2.a = '0; i2.b = '0;
        #12;
        chk("rst8", 64'({i8.busy, i8.done, i8.sum, i8.cout, i8.ovf}), 64'(0));
        chk("rst2", 64'({i2.busy, i2.done, i2.sum, i2.cout, i2.ovf}), 64'(0));
        step();
        RST = 1'b0;
        step();

        // 3 + 5
        op8(8'd3, 8'd5, 1'b0, lat, bcnt);
        chk("lat_3p5", 64'(lat), 64'(8));
        chk("busy_3p5", 64'(bcnt), 64'(8));
        res8("res_3p5", 8'd8, 1'b0, 1'b0);
        step();
        chk("done_pulse", 64'({i8.done, i8.busy}), 64'(0));
        res8("hold_3p5", 8'd8, 1'b0, 1'b0);

        op8(8'd255, 8'd1, 1'b0, lat, bcnt);
        res8("res_255p1", 8'd0, 1'b1, 1'b0);
        op8(8'd127, 8'd1, 1'b0, lat, bcnt);
        res8("res_127p1", 8'd128, 1'b0, 1'b1);
        op8(8'd5, 8'd7, 1'b1, lat, bcnt);
        res8("res_5m7", 8'd254, 1'b0, 1'b0);
        op8(8'd128, 8'd1, 1'b1, lat, bcnt);
        res8("res_128m1", 8'd127, 1'b1, 1'b1);
        step();

        // start held through RUN with new operands, then into DONE
        i8.start = 1'b1; i8.a = 8'd10; i8.b = 8'd20; i8.sub = 1'b0;
        step();
        i8.a = 8'd100; i8.b = 8'd100;
        lat = 0;
        while (!i8.done && lat < 40) begin step(); lat++; end
        chk("lat_hold", 64'(lat), 64'(8));
        res8("res_hold", 8'd30, 1'b0, 1'b0);
        step();
        i8.start = 1'b0;
        lat = 1;
        chk("b2b_busy", 64'(i8.busy), 64'(1));
        while (!i8.done && lat < 40) begin step(); lat++; end
        chk("b2b_gap", 64'(lat), 64'(9));
        res8("res_b2b", 8'd200, 1'b0, 1'b1);
        step();
        chk("b2b_idle", 64'({i8.busy, i8.done}), 64'(0));

        // reset in the 4th RUN cycle
        i8.start = 1'b1; i8.a = 8'd3; i8.b = 8'd5; i8.sub = 1'b0;
        step();
        i8.start = 1'b0;
        step(); step(); step();
        chk("busy_pre_rst", 64'(i8.busy), 64'(1));
        #2 RST = 1'b1;
        #1;
        chk("async_rst", 64'({i8.busy, i8.done, i8.sum, i8.cout, i8.ovf}), 64'(0));
        step();
        RST = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (i8.done || i8.busy) ndone++;
            step();
        end
        chk("no_done_after_abort", 64'(ndone), 64'(0));
        op8(8'd10, 8'd20, 1'b0, lat, bcnt);
        chk("lat_post_rst", 64'(lat), 64'(8));
        res8("res_post_rst", 8'd30, 1'b0, 1'b0);
        step();

        // WIDTH=2: 3 + 3
        op2(2'd3, 2'd3, 1'b0, lat);
        chk("lat2_3p3", 64'(lat), 64'(2));
        chk("res2_3p3", 64'({i2.sum, i2.cout, i2.ovf}), 64'({2'd2, 1'b1, 1'b0}));
        step();

        // WIDTH=2 exhaustive sweep against a signed/unsigned reference
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 4; a++) begin
                for (int b = 0; b < 4; b++) begin
                    int ub, full, sa, sb, r;
                    logic eo;
                    ub   = (s != 0) ? (~b & 3) : b;
                    full = a + ub + s;
                    sa   = (a >= 2) ? a - 4 : a;
                    sb   = (b >= 2) ? b - 4 : b;
                    r    = (s != 0) ? sa - sb : sa + sb;
                    eo   = (r < -2) || (r > 1);
                    op2(2'(a), 2'(b), s[0], lat);
                    chk($sformatf("sweep2_a%0d_b%0d_s%0d", a, b, s),
                        64'({lat[3:0], i2.sum, i2.cout, i2.ovf}),
                        64'({4'd2, 2'(full & 3), full[2], eo}));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor; next generation of the board-level PMOD-to-LED adder demo.
- Adds or subtracts two WIDTH-bit operands LSB-first through one full-adder cell and a carry flip-flop, one bit per clock.
- Reports registered sum, carry-out and signed overflow through a start/busy/done handshake.
- Sits between the board's operand-capture logic (PMOD/switch registers) and the LED/display drivers.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32. WIDTH=2 reproduces the original 2-bit demo.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RST  in  1  reset, asynchronous, active-high.
- start  in  1  request an operation; sampled only when busy=0.
- sub  in  1  0 = A+B, 1 = A-B; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when the result registers update.
- sum  out  WIDTH  result, low WIDTH bits.
- cout  out  1  final carry; in subtract mode 1 means no borrow (a >= b unsigned).
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset, asynchronous on RST high: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, internal shift registers, bit counter and carry flip-flop all 0. Reset mid-operation aborts the operation with no done pulse, and the outputs return to 0.
- States are IDLE, RUN and DONE. busy=1 only in RUN; done=1 only in DONE.
- IDLE or DONE with start=1 at edge k:
  - latch a into shift register A;
  - latch b (or ~b if sub=1) into shift register B;
  - carry flip-flop loads sub;
  - bit counter loads 0;
  - state goes to RUN.
- RUN, each edge:
  - s = A[0]^B[0]^c and the next carry is the majority of (A[0], B[0], c);
  - s shifts into the MSB of the result shift register, so after WIDTH shifts bit 0 sits at the LSB;
  - A and B shift right;
  - the counter increments;
  - on the edge that processes bit WIDTH-2, the incoming carry of the MSB stage is captured for ovf.
- The edge that processes bit WIDTH-1 (edge k+WIDTH):
  - sum, cout and ovf load together;
  - state goes to DONE.
- DONE lasts one cycle, then goes to IDLE unless start=1. Back-to-back start in DONE is legal and begins a new RUN with no idle gap.
- Latency: done is high during the cycle after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- Output registers only: sum, cout and ovf hold the last result until the next completion or reset. They never show partial results during RUN.
- start while busy=1 is ignored; a, b and sub may change freely during RUN.
- Arithmetic: result is (a + (sub ? ~b : b) + sub) mod 2^WIDTH, with cout as bit WIDTH of that addition.
- The bit counter is $clog2(WIDTH) bits wide; no wrap-around occurs because the RUN exit is at count WIDTH-1.

Decomposition:
- Shared package serial_adder_pkg holds:
  - the state encoding typedef (IDLE, RUN, DONE, 2 bits);
  - the localparam MAX_WIDTH=32.
- One natural sub-module, full_adder_bit: combinational 1-bit full adder with inputs a, b, cin and outputs s, cout. It is instantiated once and reused by later ripple and serial designs.
- The FSM, counter and shift registers stay in serial_adder.

Test Plan:
- WIDTH=8: a=3, b=5, sub=0, start pulse -> busy for 8 cycles; done pulse on cycle 9; sum=8, cout=0, ovf=0.
- WIDTH=8: 255+1 -> sum=0, cout=1, ovf=0. Then 127+1 -> sum=128, cout=0, ovf=1.
- WIDTH=8: sub=1, a=5, b=7 -> sum=254, cout=0, ovf=0. Then sub=1, a=128, b=1 -> sum=127, cout=1, ovf=1.
- WIDTH=8: start held high with new operands during RUN -> ignored, result from the first operands. Start high during DONE -> next RUN begins immediately, and the second done comes exactly 9 cycles after the first.
- WIDTH=8: assert RST at the 4th RUN cycle -> busy, done, sum, cout and ovf are 0 immediately (asynchronously), no done pulse. After release, 10+20 -> sum=30.
- WIDTH=2: a=3, b=3 -> sum=2, cout=1, ovf=0, done 3 cycles after start; exhaustive sweep of all 32 (a, b, sub) combinations against the reference model.
